// File: rtl/axi2apb_pkg.sv
// Shared types and payload layout helpers for the axi2apb bridge's PCLK-side logic.
package axi2apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  // Request payloads are packed {id, addr[, wdata]} with the id in the MSBs.
  localparam int WREQ_DATA_LSB = 0;
  localparam int RREQ_ADDR_LSB = 0;

  function automatic int wreq_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int wreq_id_lsb(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int rreq_id_lsb(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/apb_master_sched_rr_arb2.sv
// Two-requester round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_wr_i,
  input  logic req_rd_i,
  input  logic upd_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);

  // Resets to "read went last" so the write stream wins the first tie.
  logic last_rd_q, last_rd_d;

  assign gnt_wr_o = req_wr_i & (~req_rd_i | last_rd_q);
  assign gnt_rd_o = req_rd_i & (~req_wr_i | ~last_rd_q);

  always_comb begin
    last_rd_d = last_rd_q;
    if (upd_i) last_rd_d = gnt_rd_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_rd_q <= 1'b1;
    else       last_rd_q <= last_rd_d;
  end

endmodule

// File: rtl/apb_master_sched.sv
// APB-side scheduler: arbitrates write/read commands and runs one APB transfer at a time,
// returning an ID-tagged response for each completed or timed-out transfer.
module apb_master_sched
  import axi2apb_pkg::*;
#(
  parameter int ID_NUM   = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic                           PCLK_i,
  input  logic                           PRESET_i,
  input  logic                           wreq_vld_i,
  output logic                           wreq_rdy_o,
  input  logic [ID_NUM+ADDR_W+DATA_W-1:0] wreq_payload_i,
  input  logic                           rreq_vld_i,
  output logic                           rreq_rdy_o,
  input  logic [ID_NUM+ADDR_W-1:0]        rreq_payload_i,
  output logic                           wrsp_vld_o,
  input  logic                           wrsp_rdy_i,
  output logic [ID_NUM:0]                 wrsp_payload_o,
  output logic                           rrsp_vld_o,
  input  logic                           rrsp_rdy_i,
  output logic [ID_NUM+DATA_W:0]          rrsp_payload_o,
  output logic                           PSEL_o,
  output logic                           PENABLE_o,
  output logic                           PWRITE_o,
  output logic [ADDR_W-1:0]               PADDR_o,
  output logic [DATA_W-1:0]               PWDATA_o,
  input  logic [DATA_W-1:0]               PRDATA_i,
  input  logic                           PREADY_i,
  input  logic                           PSLVERR_i,
  output logic                           timeout_o
);

  localparam int W_ADDR_LSB = wreq_addr_lsb(DATA_W);
  localparam int W_ID_LSB   = wreq_id_lsb(ADDR_W, DATA_W);
  localparam int R_ID_LSB   = rreq_id_lsb(ADDR_W);
  localparam int WAIT_W     = $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  apb_state_e          state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ID_NUM-1:0]   id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                dir_q, dir_d;
  logic                err_q, err_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                timeout_q, timeout_d;
  logic                gnt_wr, gnt_rd, wr_hs, rd_hs, rsp_hs;

  // Valid/ready: a transfer happens on a rising PCLK edge where vld and rdy are both high;
  // a source keeps vld and payload stable until then, and rdy never waits on anything but vld.
  rr_arb2 u_arb (
    .clk_i    (PCLK_i),
    .rst_i    (PRESET_i),
    .req_wr_i (wreq_vld_i),
    .req_rd_i (rreq_vld_i),
    .upd_i    (wr_hs | rd_hs),
    .gnt_wr_o (gnt_wr),
    .gnt_rd_o (gnt_rd)
  );

  assign wreq_rdy_o = (state_q == ST_IDLE) & gnt_wr;
  assign rreq_rdy_o = (state_q == ST_IDLE) & gnt_rd;
  assign wr_hs      = wreq_vld_i & wreq_rdy_o;
  assign rd_hs      = rreq_vld_i & rreq_rdy_o;
  assign rsp_hs     = (dir_q == DIR_WR) ? wrsp_rdy_i : rrsp_rdy_i;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    id_d       = id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    dir_d      = dir_q;
    err_d      = err_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_hs) begin
          id_d       = wreq_payload_i[W_ID_LSB +: ID_NUM];
          addr_d     = wreq_payload_i[W_ADDR_LSB +: ADDR_W];
          wdata_d    = wreq_payload_i[WREQ_DATA_LSB +: DATA_W];
          dir_d      = DIR_WR;
          rdata_d    = '0;
          err_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_SETUP;
        end else if (rd_hs) begin
          id_d       = rreq_payload_i[R_ID_LSB +: ID_NUM];
          addr_d     = rreq_payload_i[RREQ_ADDR_LSB +: ADDR_W];
          wdata_d    = '0;
          dir_d      = DIR_RD;
          rdata_d    = '0;
          err_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY_i) begin
          err_d   = PSLVERR_i;
          if (dir_q == DIR_RD) rdata_d = PRDATA_i;
          state_d = ST_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Slave stalled for WAIT_MAX cycles: complete with an error instead of hanging the bus.
          err_d     = 1'b1;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      dir_q      <= DIR_RD;
      err_q      <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      timeout_q  <= timeout_d;
    end
  end

  assign PSEL_o         = psel_q;
  assign PENABLE_o      = penable_q;
  assign PWRITE_o       = dir_q;
  assign PADDR_o        = addr_q;
  assign PWDATA_o       = wdata_q;
  assign timeout_o      = timeout_q;
  assign wrsp_vld_o     = (state_q == ST_RESP) && (dir_q == DIR_WR);
  assign rrsp_vld_o     = (state_q == ST_RESP) && (dir_q == DIR_RD);
  assign wrsp_payload_o = {id_q, err_q};
  assign rrsp_payload_o = {id_q, rdata_q, err_q};

endmodule
